// File: rtl/rca_seq_multiplier_if.sv
// Start/busy/done handshake bundle for rca_seq_multiplier.
// Optional MUL_SIGNED_EN adds the sgn request field.
// master = requester (core side), slave = multiplier.
interface rca_seq_multiplier_if #(
  parameter int unsigned N = 32
);
  logic           start;
  logic           flush;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
`ifdef MUL_SIGNED_EN
  logic           sgn;
`endif
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
`ifdef MUL_SIGNED_EN
    output sgn,
`endif
    output start, flush, a, b,
    input  busy, done, product
  );

  modport slave (
`ifdef MUL_SIGNED_EN
    input  sgn,
`endif
    input  start, flush, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/rca_seq_multiplier.sv
// Sequential shift-and-add multiplier built around one N-bit ripple-carry adder.
// Produces the full 2N-bit product after N accumulate cycles plus one DONE cycle.
// Define MUL_SIGNED_EN to add the sgn request field (signed magnitude handling).

// N-bit ripple-carry adder reused every accumulate cycle.
module rca #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] carry;

  // Bit-serial carry chain, LSB first.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i]     = x[i] ^ y[i] ^ carry[i];
      carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end
    cout = carry[N];
  end
endmodule

module rca_seq_multiplier #(
  parameter  int unsigned N  = 32,
  localparam int unsigned CW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  rca_seq_multiplier_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state;
  logic [N-1:0]   mcand;
  logic [N-1:0]   hi;
  logic [N-1:0]   lo;
  logic [CW-1:0]  cnt;
`ifdef MUL_SIGNED_EN
  logic           neg;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
`endif

  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic           cout;
  logic [2*N-1:0] next_acc;

  // Partial product: add multiplicand only when the current multiplier bit is set.
  always_comb begin
    addend   = lo[0] ? mcand : '0;
    // Carry-out becomes the new MSB of hi so the all-ones case keeps its top bit.
    next_acc = {cout, sum, lo[N-1:1]};
  end

  rca #(.N(N)) u_rca (
    .x    (hi),
    .y    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

`ifdef MUL_SIGNED_EN
  // Operand magnitudes for the signed request.
  always_comb begin
    a_mag = (bus.sgn && bus.a[N-1]) ? -bus.a : bus.a;
    b_mag = (bus.sgn && bus.b[N-1]) ? -bus.b : bus.b;
  end
`endif

  // Control FSM plus datapath registers; outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mcand       <= '0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
`ifdef MUL_SIGNED_EN
      neg         <= 1'b0;
`endif
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= '0;
    end else if (bus.flush) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
`ifdef MUL_SIGNED_EN
            mcand <= a_mag;
            lo    <= b_mag;
            neg   <= bus.sgn & (bus.a[N-1] ^ bus.b[N-1]);
`else
            mcand <= bus.a;
            lo    <= bus.b;
`endif
            hi       <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          hi  <= next_acc[2*N-1:N];
          lo  <= next_acc[N-1:0];
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            // Product is taken straight from the final accumulate result so it
            // is valid in the same cycle done is high.
`ifdef MUL_SIGNED_EN
            bus.product <= neg ? -next_acc : next_acc;
`else
            bus.product <= next_acc;
`endif
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          cnt      <= '0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rca_seq_multiplier.sv
// Directed bench for rca_seq_multiplier (N=32).
// Signed cases are compiled in only when MUL_SIGNED_EN is defined.
module tb_rca_seq_multiplier;
  localparam int unsigned N = 32;

  logic clk;
  logic rst;
  int   cmp_n;
  int   err_n;

  rca_seq_multiplier_if #(.N(N)) bus ();

  rca_seq_multiplier #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for exactly one rising edge; returns at the negedge after acceptance.
  task automatic do_start(input logic [N-1:0] av, input logic [N-1:0] bv);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Observe a running operation until busy drops (bounded).
  task automatic wait_obs(output int cycles, output int ndone, output int done_at,
                          output logic [2*N-1:0] prod);
    cycles  = 0;
    ndone   = 0;
    done_at = -1;
    prod    = '0;
    while (bus.busy === 1'b1 && cycles < 200) begin
      if (bus.done === 1'b1) begin
        ndone++;
        done_at = cycles;
        prod    = bus.product;
      end
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    cmp_n++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      err_n++;
      $display("FAIL reset_flags: got busy/done %b expected 00", {bus.busy, bus.done});
    end
    cmp_n++;
    if (bus.product !== 64'h0) begin
      err_n++;
      $display("FAIL reset_product: got %h expected %h", bus.product, 64'h0);
    end
    // start during reset must not be accepted
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    @(negedge clk);
    @(negedge clk);
    cmp_n++;
    if (bus.busy !== 1'b0) begin
      err_n++;
      $display("FAIL reset_hold: got busy %b expected 0", bus.busy);
    end
    bus.start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, nd, dat;
    logic [2*N-1:0] p;
    do_start(32'd7, 32'd6);
    wait_obs(cyc, nd, dat, p);
    cmp_n++;
    if (cyc !== 33) begin
      err_n++;
      $display("FAIL basic_busy_cycles: got %0d expected 33", cyc);
    end
    cmp_n++;
    if (dat !== 32) begin
      err_n++;
      $display("FAIL basic_done_cycle: got %0d expected 32", dat);
    end
    cmp_n++;
    if (nd !== 1) begin
      err_n++;
      $display("FAIL basic_done_count: got %0d expected 1", nd);
    end
    cmp_n++;
    if (p !== 64'h00000000_0000002A) begin
      err_n++;
      $display("FAIL basic_product: got %h expected %h", p, 64'h2A);
    end
    @(negedge clk);
    cmp_n++;
    if (bus.product !== 64'h2A || bus.done !== 1'b0) begin
      err_n++;
      $display("FAIL basic_hold: got product %h done %b expected %h done 0",
               bus.product, bus.done, 64'h2A);
    end
  endtask

  task automatic test_vectors;
    logic [N-1:0]   av [4];
    logic [N-1:0]   bv [4];
    logic [2*N-1:0] ev [4];
    int cyc, nd, dat;
    logic [2*N-1:0] p;
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'hFFFF_FFFF; ev[0] = 64'hFFFFFFFE_00000001;
    av[1] = 32'h8000_0000; bv[1] = 32'h8000_0000; ev[1] = 64'h40000000_00000000;
    av[2] = 32'h0001_0000; bv[2] = 32'h0001_0001; ev[2] = 64'h00000001_00010000;
    av[3] = 32'h0000_0000; bv[3] = 32'h0000_0005; ev[3] = 64'h0;
    for (int i = 0; i < 4; i++) begin
      do_start(av[i], bv[i]);
      wait_obs(cyc, nd, dat, p);
      cmp_n++;
      if (nd !== 1 || p !== ev[i]) begin
        err_n++;
        $display("FAIL vector%0d: got product %h done count %0d expected %h done count 1",
                 i, p, nd, ev[i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int cyc, nd, extra;
    logic [2*N-1:0] p;
    do_start(32'd3, 32'd4);
    repeat (4) @(negedge clk);
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    nd  = 0;
    cyc = 0;
    p   = '0;
    extra = 0;
    while (cyc < 80) begin
      if (bus.done === 1'b1) begin
        nd++;
        p = bus.product;
      end
      if (bus.busy === 1'b1 && nd > 0 && bus.done !== 1'b1) extra++;
      cyc++;
      @(negedge clk);
    end
    cmp_n++;
    if (p !== 64'h0C) begin
      err_n++;
      $display("FAIL busy_start_product: got %h expected %h", p, 64'h0C);
    end
    cmp_n++;
    if (nd !== 1 || extra !== 0) begin
      err_n++;
      $display("FAIL busy_start_ignored: got done count %0d busy-after-done %0d expected 1 and 0",
               nd, extra);
    end
  endtask

  task automatic test_flush;
    int nd;
    do_start(32'd5, 32'd5);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    cmp_n++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'h0C) begin
      err_n++;
      $display("FAIL flush_abort: got busy %b done %b product %h expected 0 0 %h",
               bus.busy, bus.done, bus.product, 64'h0C);
    end
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
      @(negedge clk);
    end
    cmp_n++;
    if (nd !== 0) begin
      err_n++;
      $display("FAIL flush_no_done: got %0d active cycles expected 0", nd);
    end
    // flush wins over start in IDLE
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.a     = 32'd2;
    bus.b     = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    cmp_n++;
    if (bus.busy !== 1'b0) begin
      err_n++;
      $display("FAIL flush_beats_start: got busy %b expected 0", bus.busy);
    end
  endtask

  task automatic test_rst_mid;
    int cyc, nd, dat;
    logic [2*N-1:0] p;
    do_start(32'd123, 32'd456);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    cmp_n++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'h0) begin
      err_n++;
      $display("FAIL rst_mid_abort: got busy %b done %b product %h expected 0 0 0",
               bus.busy, bus.done, bus.product);
    end
    @(negedge clk);
    rst = 1'b1;
    do_start(32'hFFFF_FFFF, 32'd2);
    wait_obs(cyc, nd, dat, p);
    cmp_n++;
    if (nd !== 1 || p !== 64'h00000001_FFFFFFFE || cyc !== 33) begin
      err_n++;
      $display("FAIL rst_mid_recover: got product %h done count %0d busy %0d expected %h 1 33",
               p, nd, cyc, 64'h00000001_FFFFFFFE);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, nd, dat;
    logic [2*N-1:0] p;
    @(negedge clk);
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    cmp_n++;
    if (bus.done !== 1'b1 || bus.product !== 64'd6 || cyc !== 32) begin
      err_n++;
      $display("FAIL b2b_first: got done %b product %h at cycle %0d expected 1 %h at 32",
               bus.done, bus.product, cyc, 64'd6);
    end
    // start still held; new operands must wait for IDLE
    bus.a = 32'd4;
    bus.b = 32'd5;
    @(negedge clk);
    cmp_n++;
    if (bus.busy !== 1'b0) begin
      err_n++;
      $display("FAIL b2b_idle_gap: got busy %b expected 0", bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    cmp_n++;
    if (bus.busy !== 1'b1) begin
      err_n++;
      $display("FAIL b2b_reaccept: got busy %b expected 1", bus.busy);
    end
    wait_obs(cyc, nd, dat, p);
    cmp_n++;
    if (nd !== 1 || p !== 64'd20) begin
      err_n++;
      $display("FAIL b2b_second: got product %h done count %0d expected %h 1", p, nd, 64'd20);
    end
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed;
    logic [N-1:0]   av [3];
    logic [N-1:0]   bv [3];
    logic           sv [3];
    logic [2*N-1:0] ev [3];
    int cyc, nd, dat;
    logic [2*N-1:0] p;
    av[0] = 32'hFFFF_FFFD; bv[0] = 32'd5;         sv[0] = 1'b1; ev[0] = 64'hFFFFFFFF_FFFFFFF1;
    av[1] = 32'h8000_0000; bv[1] = 32'h8000_0000; sv[1] = 1'b1; ev[1] = 64'h40000000_00000000;
    av[2] = 32'hFFFF_FFFF; bv[2] = 32'hFFFF_FFFF; sv[2] = 1'b0; ev[2] = 64'hFFFFFFFE_00000001;
    for (int i = 0; i < 3; i++) begin
      bus.sgn = sv[i];
      do_start(av[i], bv[i]);
      wait_obs(cyc, nd, dat, p);
      cmp_n++;
      if (nd !== 1 || p !== ev[i]) begin
        err_n++;
        $display("FAIL signed%0d: got product %h done count %0d expected %h 1", i, p, nd, ev[i]);
      end
    end
    bus.sgn = 1'b0;
  endtask
`endif

  initial begin
    cmp_n     = 0;
    err_n     = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MUL_SIGNED_EN
    bus.sgn   = 1'b0;
`endif
    test_reset;
    test_basic;
    test_vectors;
    test_start_while_busy;
    test_flush;
    test_rst_mid;
    test_back_to_back;
`ifdef MUL_SIGNED_EN
    test_signed;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
